// File: rtl/relax_if.sv
// Handshake and status bundle between the relaxation sequencer and its
// controller: phase request, settle feedback, strobes and per-phase results.
interface relax_if #(
  parameter int unsigned CW = 8
);
  logic          start;
  logic          settle_in;
  logic          node_init;
  logic          upd_en;
  logic          pad_sample;
  logic          done;
  logic          timeout;
  logic          busy;
  logic [CW-1:0] iter_cnt;

  modport master (
    output start, settle_in,
    input  node_init, upd_en, pad_sample, done, timeout, busy, iter_cnt
  );

  modport slave (
    input  start, settle_in,
    output node_init, upd_en, pad_sample, done, timeout, busy, iter_cnt
  );
endinterface

// File: rtl/relax_sequencer.sv
// Node-relaxation sequencer: init window after reset, then per phase issues
// update strobes until the node array settles or the iteration limit hits.
module relax_sequencer #(
  parameter int unsigned MAX_ITER    = 64,
  parameter int unsigned MIN_ITER    = 4,
  parameter int unsigned SETTLE_RUN  = 2,
  parameter int unsigned INIT_CYCLES = 16,
  parameter int unsigned CW          = 8
) (
  input logic     eclk,
  input logic     erst,
  relax_if.slave  bus
);

  localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CW-1:0] MAX_N   = CW'(MAX_ITER);
  localparam logic [CW-1:0] MIN_N   = CW'(MIN_ITER);
  localparam logic [CW-1:0] SR_N    = CW'(SETTLE_RUN);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RUN,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t        state, state_d;
  logic [IW-1:0] init_cnt, init_cnt_d;
  logic [CW-1:0] n, n_d, n_inc;
  logic [CW-1:0] s, s_d, s_inc;
  logic [CW-1:0] iter_d;
  logic          timeout_d;
  logic          node_init_d, busy_d, upd_en_d, pad_sample_d, done_d;

  // State, counters and all outputs; erst wins at every edge.
  always_ff @(posedge eclk) begin
    if (erst) begin
      state          <= S_INIT;
      init_cnt       <= '0;
      n              <= '0;
      s              <= '0;
      bus.node_init  <= 1'b1;
      bus.busy       <= 1'b1;
      bus.upd_en     <= 1'b0;
      bus.pad_sample <= 1'b0;
      bus.done       <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.iter_cnt   <= '0;
    end else begin
      state          <= state_d;
      init_cnt       <= init_cnt_d;
      n              <= n_d;
      s              <= s_d;
      bus.node_init  <= node_init_d;
      bus.busy       <= busy_d;
      bus.upd_en     <= upd_en_d;
      bus.pad_sample <= pad_sample_d;
      bus.done       <= done_d;
      bus.timeout    <= timeout_d;
      bus.iter_cnt   <= iter_d;
    end
  end

  // Next state, counter updates and next-cycle output values.
  always_comb begin
    state_d    = state;
    init_cnt_d = init_cnt;
    n_d        = n;
    s_d        = s;
    iter_d     = bus.iter_cnt;
    timeout_d  = bus.timeout;
    n_inc      = n + CW'(1);
    // Settle run length saturates so it can never wrap during a long phase.
    s_inc      = bus.settle_in ? ((s == SR_N) ? SR_N : s + CW'(1)) : '0;

    case (state)
      S_INIT: begin
        if (init_cnt == INIT_LAST) state_d = S_IDLE;
        else                       init_cnt_d = init_cnt + IW'(1);
      end
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          n_d     = '0;
          s_d     = '0;
        end
      end
      S_RUN: begin
        n_d = n_inc;
        s_d = s_inc;
        if (n_inc >= MIN_N && s_inc >= SR_N) begin
          state_d   = S_SAMPLE;
          iter_d    = n_inc;
          timeout_d = 1'b0;
        end else if (n_inc == MAX_N) begin
          state_d   = S_SAMPLE;
          iter_d    = MAX_N;
          timeout_d = 1'b1;
        end
      end
      S_SAMPLE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase

    node_init_d  = (state_d == S_INIT);
    busy_d       = (state_d != S_IDLE);
    upd_en_d     = (state_d == S_RUN);
    pad_sample_d = (state_d == S_SAMPLE);
    done_d       = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_relax_sequencer.sv
// Self-checking bench for relax_sequencer: directed scenarios plus randomized
// settle patterns compared against a phase-level reference model.
module tb_relax_sequencer;

  localparam int MAX_ITER    = 64;
  localparam int MIN_ITER    = 4;
  localparam int SETTLE_RUN  = 2;
  localparam int INIT_CYCLES = 16;
  localparam int CW          = 8;

  logic eclk = 1'b0;
  logic erst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   pat [1:MAX_ITER];

  relax_if #(.CW(CW)) bus ();

  relax_sequencer #(
    .MAX_ITER(MAX_ITER), .MIN_ITER(MIN_ITER), .SETTLE_RUN(SETTLE_RUN),
    .INIT_CYCLES(INIT_CYCLES), .CW(CW)
  ) dut (
    .eclk(eclk),
    .erst(erst),
    .bus (bus)
  );

  always #5 eclk = ~eclk;

  // {node_init, busy, upd_en, pad_sample, done, timeout}
  function automatic logic [5:0] flags();
    return {bus.node_init, bus.busy, bus.upd_en, bus.pad_sample, bus.done, bus.timeout};
  endfunction

  // Phase outcome straight from the rules: first update cycle k with k >= MIN_ITER
  // and at least SETTLE_RUN consecutive settled cycles ending at k, else timeout.
  function automatic void model(output int it, output bit to);
    int run = 0;
    for (int k = 1; k <= MAX_ITER; k++) begin
      run = pat[k] ? run + 1 : 0;
      if (k >= MIN_ITER && run >= SETTLE_RUN) begin
        it = k; to = 1'b0; return;
      end
    end
    it = MAX_ITER; to = 1'b1;
  endfunction

  // One full phase from IDLE (called #1 after an edge while IDLE).
  task automatic run_phase(input string name, input bit noisy_start);
    int exp_it; bit exp_to; int cnt;
    model(exp_it, exp_to);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL %s idle_before_start: busy=%b want 0", name, bus.busy);
    end
    bus.start = 1'b1;
    @(posedge eclk); #1;
    bus.start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      if (bus.upd_en !== 1'b1) break;
      cnt++;
      total++;
      if (bus.pad_sample !== 1'b0 || bus.node_init !== 1'b0 || bus.done !== 1'b0) begin
        bad++; $display("FAIL %s strobe_overlap: cycle %0d flags=%b", name, cnt, flags());
      end
      bus.settle_in = (cnt <= MAX_ITER) ? pat[cnt] : 1'b0;
      if (noisy_start) bus.start = 1'($urandom_range(0, 1));
      @(posedge eclk); #1;
    end
    bus.start = 1'b0;
    total++;
    if (cnt !== exp_it) begin
      bad++; $display("FAIL %s upd_cycles: got %0d want %0d", name, cnt, exp_it);
    end
    total++;
    if (flags() !== {3'b010, 1'b1, 1'b0, exp_to} || bus.iter_cnt !== CW'(exp_it)) begin
      bad++; $display("FAIL %s sample_cycle: flags=%b iter=%0d want flags=%b iter=%0d",
                      name, flags(), bus.iter_cnt, {3'b010, 1'b1, 1'b0, exp_to}, exp_it);
    end
    @(posedge eclk); #1;
    total++;
    if (flags() !== {3'b010, 1'b0, 1'b1, exp_to}) begin
      bad++; $display("FAIL %s done_cycle: flags=%b want %b", name, flags(), {3'b010, 1'b0, 1'b1, exp_to});
    end
    @(posedge eclk); #1;
    total++;
    if (flags() !== {5'b00000, exp_to} || bus.iter_cnt !== CW'(exp_it)) begin
      bad++; $display("FAIL %s idle_after: flags=%b iter=%0d want flags=%b iter=%0d",
                      name, flags(), bus.iter_cnt, {5'b00000, exp_to}, exp_it);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.settle_in = 1'b0;
    erst = 1'b1;
    repeat (3) begin
      @(posedge eclk); #1;
      total++;
      if (flags() !== 6'b110000 || bus.iter_cnt !== '0) begin
        bad++; $display("FAIL reset_hold: flags=%b iter=%0d want 110000 iter=0", flags(), bus.iter_cnt);
      end
    end
    erst = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < INIT_CYCLES; i++) begin
      total++;
      if (flags() !== 6'b110000) begin
        bad++; $display("FAIL init_window: cycle %0d flags=%b want 110000", i + 1, flags());
      end
      if (i == INIT_CYCLES - 1) bus.start = 1'b0;
      @(posedge eclk); #1;
    end
    total++;
    if (flags() !== 6'b000000 || bus.iter_cnt !== '0) begin
      bad++; $display("FAIL init_exit: flags=%b iter=%0d want 000000 iter=0", flags(), bus.iter_cnt);
    end
  endtask

  task automatic test_fast_settle();
    for (int k = 1; k <= MAX_ITER; k++) pat[k] = 1'b1;
    run_phase("fast_settle", 1'b0);
  endtask

  task automatic test_late_settle();
    for (int k = 1; k <= MAX_ITER; k++) pat[k] = (k >= 10);
    run_phase("late_settle", 1'b0);
  endtask

  task automatic test_glitchy_settle();
    for (int k = 1; k <= MAX_ITER; k++) pat[k] = k[0];
    run_phase("glitchy_settle", 1'b0);
    for (int k = 1; k <= MAX_ITER; k++) pat[k] = 1'b1;
    run_phase("timeout_clear", 1'b0);
  endtask

  task automatic test_random_noisy_start();
    for (int r = 0; r < 8; r++) begin
      int bias = $urandom_range(1, 4);
      for (int k = 1; k <= MAX_ITER; k++) pat[k] = ($urandom_range(0, 4) < bias);
      run_phase($sformatf("random_%0d", r), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    bus.settle_in = 1'b1;
    bus.start = 1'b1;
    @(posedge eclk); #1;
    for (int p = 0; p < 2; p++) begin
      cnt = 0;
      for (int c = 0; c < 200 && bus.upd_en === 1'b1; c++) begin
        cnt++;
        @(posedge eclk); #1;
      end
      total++;
      if (cnt !== MIN_ITER || bus.pad_sample !== 1'b1) begin
        bad++; $display("FAIL b2b_phase%0d: upd=%0d pad=%b want upd=%0d pad=1", p, cnt, bus.pad_sample, MIN_ITER);
      end
      @(posedge eclk); #1;
      total++;
      if (bus.done !== 1'b1) begin
        bad++; $display("FAIL b2b_done%0d: done=%b want 1", p, bus.done);
      end
      @(posedge eclk); #1;
      total++;
      if (bus.busy !== 1'b0 || bus.upd_en !== 1'b0) begin
        bad++; $display("FAIL b2b_gap%0d: busy=%b upd=%b want 0 0", p, bus.busy, bus.upd_en);
      end
      @(posedge eclk); #1;
      total++;
      if (bus.upd_en !== 1'b1) begin
        bad++; $display("FAIL b2b_restart%0d: upd=%b want 1", p, bus.upd_en);
      end
    end
    bus.start = 1'b0;
    for (int c = 0; c < 100 && bus.busy !== 1'b0; c++) begin
      @(posedge eclk); #1;
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL b2b_drain: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_mid_reset();
    int cnt = 0;
    bit strobe_seen = 1'b0;
    bus.settle_in = 1'b0;
    bus.start = 1'b1;
    @(posedge eclk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 20 && cnt < 5; c++) begin
      if (bus.upd_en === 1'b1) cnt++;
      if (cnt < 5) begin
        @(posedge eclk); #1;
      end
    end
    erst = 1'b1;
    @(posedge eclk); #1;
    erst = 1'b0;
    total++;
    if (cnt !== 5 || flags() !== 6'b110000 || bus.iter_cnt !== '0) begin
      bad++; $display("FAIL mid_reset: cnt=%0d flags=%b iter=%0d want cnt=5 flags=110000 iter=0",
                      cnt, flags(), bus.iter_cnt);
    end
    for (int i = 0; i < INIT_CYCLES; i++) begin
      if (bus.pad_sample !== 1'b0 || bus.done !== 1'b0 || bus.upd_en !== 1'b0 || bus.node_init !== 1'b1)
        strobe_seen = 1'b1;
      @(posedge eclk); #1;
    end
    total++;
    if (strobe_seen !== 1'b0 || flags() !== 6'b000000) begin
      bad++; $display("FAIL mid_reset_reinit: stray=%b flags=%b want stray=0 flags=000000", strobe_seen, flags());
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.settle_in = 1'b0;
    test_reset();
    test_fast_settle();
    test_late_settle();
    test_glitchy_settle();
    test_random_noisy_start();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
